// File: rtl/peak_freq_est.sv
// Peak-bin finder with phase-vocoder frequency refinement over 512-bin frames.
// Optional voicing gate enabled by defining PEAK_FREQ_EST_MAG_THRESH_EN.
module peak_freq_est #(
  parameter int          NBINS     = 512,
  parameter int          MIN_BIN   = 2,
  parameter int          MAX_BIN   = 511,
  parameter int          HOP_LOG2  = 2,
  parameter logic [16:0] INV_SCALE = 17'd41722
`ifdef PEAK_FREQ_EST_MAG_THRESH_EN
  ,
  parameter logic [31:0] MAG_THRESH = 32'd4096
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               bin_valid,
  input  logic [31:0]        bin_mag,
  input  logic signed [31:0] bin_phase,
  output logic               busy,
  output logic               done,
  output logic [8:0]         peak_bin,
  output logic [31:0]        peak_mag,
  output logic signed [31:0] freq_est,
  output logic               freq_valid,
  output logic               voiced,
  output logic [2:0]         dbg_state
);

  // Stream contract: bin_valid qualifies bin_mag/bin_phase for exactly one cycle with
  // no backpressure; done is a one-cycle pulse and all results hold until the next done.

  typedef enum logic [2:0] {IDLE, SCAN, RD, DIFF, WRAP1, WRAP2, MUL} state_t;

  localparam logic signed [34:0] PI_Q     = 35'sd1686629713;
  localparam logic signed [34:0] TWO_PI   = 35'sd3373259426;
  localparam logic [8:0]         LAST_BIN = 9'(NBINS - 1);

  state_t                state, state_nxt;
  logic                  parity, prev_valid;
  logic [8:0]            cnt, cnt_eff;
  logic [31:0]           max_mag, max_mag_eff;
  logic [8:0]            max_bin, max_bin_eff;
  logic [31:0]           max_phase, max_phase_eff;
  logic [31:0]           rd_data;
  logic signed [34:0]    raw, exp_adv;
  logic [36:0]           exp_prod;
  logic signed [52:0]    prod;
  logic signed [53:0]    sum;
  logic signed [31:0]    freq_sat, freq_base;
  logic                  accept_start, bin_take, eligible, last_bin;
  logic                  voiced_nxt, freq_valid_nxt;
  logic [31:0]           phase_mem [2*NBINS];

  assign accept_start = frame_start && (state == IDLE || state == SCAN);
  assign bin_take     = bin_valid && (accept_start || state == SCAN);

  // A start in the same cycle as a bin makes that bin index 0 of the new frame.
  always_comb begin
    cnt_eff       = cnt;
    max_mag_eff   = max_mag;
    max_bin_eff   = max_bin;
    max_phase_eff = max_phase;
    if (accept_start) begin
      cnt_eff       = '0;
      max_mag_eff   = '0;
      max_bin_eff   = 9'(MIN_BIN);
      max_phase_eff = '0;
    end
  end

  assign eligible = bin_take && (int'(cnt_eff) >= MIN_BIN) && (int'(cnt_eff) <= MAX_BIN)
                    && (bin_mag > max_mag_eff);
  assign last_bin = bin_take && (cnt_eff == LAST_BIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, SCAN: begin
        if (last_bin)          state_nxt = RD;
        else if (accept_start) state_nxt = SCAN;
      end
      RD:      state_nxt = DIFF;
      DIFF:    state_nxt = WRAP1;
      WRAP1:   state_nxt = WRAP2;
      WRAP2:   state_nxt = MUL;
      MUL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      max_mag   <= '0;
      max_bin   <= 9'(MIN_BIN);
      max_phase <= '0;
    end else if (state == IDLE || state == SCAN) begin
      cnt <= bin_take ? cnt_eff + 9'd1 : cnt_eff;
      if (eligible) begin
        max_mag   <= bin_mag;
        max_bin   <= cnt_eff;
        max_phase <= bin_phase;
      end else begin
        max_mag   <= max_mag_eff;
        max_bin   <= max_bin_eff;
        max_phase <= max_phase_eff;
      end
    end
  end

  // Ping-pong phase store: current frame writes bank[parity], previous frame sits in the other.
  always_ff @(posedge clk) begin
    if (bin_take)     phase_mem[{parity, cnt_eff}] <= bin_phase;
    if (state == RD)  rd_data <= phase_mem[{~parity, max_bin}];
  end

  assign exp_prod = 37'(max_bin[HOP_LOG2-1:0]) * 37'(TWO_PI);
  assign exp_adv  = $signed(35'(exp_prod >> HOP_LOG2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw <= '0;
    end else begin
      case (state)
        DIFF: raw <= 35'($signed(max_phase)) - 35'($signed(rd_data)) - exp_adv;
        WRAP1, WRAP2: begin
          if (raw >= PI_Q)       raw <= raw - TWO_PI;
          else if (raw < -PI_Q)  raw <= raw + TWO_PI;
        end
        default: ;
      endcase
    end
  end

  assign prod      = 53'(raw) * 53'($signed({1'b0, INV_SCALE}));
  assign sum       = $signed({23'd0, max_bin, 22'd0}) + 54'(prod >>> 23);
  assign freq_base = $signed({1'b0, max_bin, 22'd0});

  always_comb begin
    if (sum > 54'sd2147483647)        freq_sat = 32'sh7fff_ffff;
    else if (sum < -54'sd2147483648)  freq_sat = 32'sh8000_0000;
    else                              freq_sat = sum[31:0];
  end

`ifdef PEAK_FREQ_EST_MAG_THRESH_EN
  logic voiced_q;
  assign voiced_nxt = (max_mag >= MAG_THRESH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            voiced_q <= 1'b0;
    else if (state == MUL) voiced_q <= voiced_nxt;
  end
  assign voiced = voiced_q;
`else
  assign voiced_nxt = 1'b1;
  assign voiced     = 1'b1;
`endif

  assign freq_valid_nxt = prev_valid && voiced_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      freq_est   <= '0;
      freq_valid <= 1'b0;
      parity     <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      done <= (state == MUL);
      if (state == MUL) begin
        peak_bin   <= max_bin;
        peak_mag   <= max_mag;
        freq_est   <= freq_valid_nxt ? freq_sat : freq_base;
        freq_valid <= freq_valid_nxt;
        parity     <= ~parity;
        prev_valid <= 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
